// File: rtl/rsu_boot_ctrl_if.sv
// Purpose: signal bundle between the factory-image boot sequencer and the vendor remote-update IP.
// Ports: master = sequencer side (drives reset/param/strobes/data_in/reconfig, reads busy/data_out),
//        slave  = remote-update IP side (mirror image).
interface rsu_boot_ctrl_if;
    logic        rsu_reset;
    logic        rsu_busy;
    logic [2:0]  rsu_param;
    logic        rsu_read_param;
    logic        rsu_write_param;
    logic [23:0] rsu_data_in;
    logic [28:0] rsu_data_out;
    logic        rsu_reconfig;

    modport master (
        output rsu_reset,
        output rsu_param,
        output rsu_read_param,
        output rsu_write_param,
        output rsu_data_in,
        output rsu_reconfig,
        input  rsu_busy,
        input  rsu_data_out
    );

    modport slave (
        input  rsu_reset,
        input  rsu_param,
        input  rsu_read_param,
        input  rsu_write_param,
        input  rsu_data_in,
        input  rsu_reconfig,
        output rsu_busy,
        output rsu_data_out
    );
endinterface

// File: rtl/rsu_boot_ctrl.sv
// Purpose: factory-image remote-update sequencer: reads the reconfig trigger, holds SPI bypass
//          while mode_n is low, programs boot address (+ optional watchdog) and requests reconfig.
// Ports: clock/reset (sync, active-high), mode_n, image_sel, rsu (remote-update IP, master side),
//        bypass_spi, trigger, fault, done.
// Latency/backpressure: one register stage per step; the FSM stalls while the IP is busy or a
//          strobe is still visible, and a per-access busy timeout forces the ERROR state.
module rsu_boot_ctrl #(
    parameter int          NUM_IMAGES   = 2,
    parameter logic [23:0] IMAGE_BASE   = 24'h100000,
    parameter logic [23:0] IMAGE_STRIDE = 24'h100000,
    parameter bit          WDT_ENABLE   = 1'b0,
    parameter logic [11:0] WDT_TIMEOUT  = 12'h000,
    parameter logic [4:0]  ERROR_MASK   = 5'b01011,
    parameter int          BUSY_TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mode_n,
    input  logic [2:0]             image_sel,
    rsu_boot_ctrl_if.master        rsu,
    output logic                   bypass_spi,
    output logic [4:0]             trigger,
    output logic [1:0]             fault,
    output logic                   done
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(BUSY_TIMEOUT);

    typedef enum logic [3:0] {
        S_RESET, S_SETTLE, S_READ_TRIG, S_FETCH, S_HOLD, S_WR_ADDR,
        S_WR_WDT, S_WR_WDT_EN, S_RECONFIG, S_DONE, S_ERROR
    } state_t;

    state_t         state_q, state_d;
    logic           rsu_reset_q, rsu_reset_d;
    logic [2:0]     param_q, param_d;
    logic [23:0]    data_q, data_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic           reconfig_q, reconfig_d;
    logic [4:0]     trigger_q, trigger_d;
    logic [1:0]     fault_q, fault_d;
    logic [2:0]     sel_q, sel_d;
    logic           settle_q, settle_d;
    logic [CW-1:0]  cnt_q;

    logic           gate_c;
    logic           active_c;
    logic           tmo_c;
    logic           trig_err_c;
    logic           sel_bad_c;
    logic [23:0]    addr_c;
    logic           unused_data_hi;

    // Upper read-data bits carry other RSU parameters that this sequencer never consumes.
    assign unused_data_hi = ^rsu.rsu_data_out[28:5];

    // A strobe still on the bus counts as "IP occupied": this spaces accesses by at least
    // one idle cycle and guarantees every strobe is exactly one cycle wide.
    assign gate_c     = (state_q == S_RESET) ||
                        (!rsu.rsu_busy && !rd_q && !wr_q);
    assign active_c   = (state_q != S_RESET) && (state_q != S_DONE) && (state_q != S_ERROR);
    assign tmo_c      = active_c && (cnt_q == TMO_LIMIT);
    assign trig_err_c = |(rsu.rsu_data_out[4:0] & ERROR_MASK);
    assign sel_bad_c  = (int'(image_sel) >= NUM_IMAGES);
    // 24-bit context: the address wraps modulo 2^24 by construction.
    assign addr_c     = IMAGE_BASE + ({21'b0, sel_q} * IMAGE_STRIDE);

    // State register and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_RESET;
            rsu_reset_q <= 1'b1;
            param_q     <= 3'b000;
            data_q      <= 24'h000000;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            reconfig_q  <= 1'b0;
            trigger_q   <= 5'b00000;
            fault_q     <= 2'd0;
            sel_q       <= 3'd0;
            settle_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsu_reset_q <= rsu_reset_d;
            param_q     <= param_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            reconfig_q  <= reconfig_d;
            trigger_q   <= trigger_d;
            fault_q     <= fault_d;
            sel_q       <= sel_d;
            settle_q    <= settle_d;
        end
    end

    // Busy watchdog: restarts with every access, saturates at the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (rd_q || wr_q || !active_c) begin
            cnt_q <= '0;
        end else if (rsu.rsu_busy && (cnt_q != TMO_LIMIT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (tmo_c) begin
            state_d = S_ERROR;
        end else if (gate_c) begin
            case (state_q)
                S_RESET:     state_d = S_SETTLE;
                S_SETTLE:    if (settle_q) state_d = S_READ_TRIG;
                S_READ_TRIG: state_d = S_FETCH;
                S_FETCH: begin
                    if (trig_err_c || sel_bad_c) state_d = S_ERROR;
                    else                         state_d = S_HOLD;
                end
                S_HOLD:      if (mode_n) state_d = S_WR_ADDR;
                S_WR_ADDR:   state_d = S_WR_WDT;
                S_WR_WDT:    state_d = WDT_ENABLE ? S_WR_WDT_EN : S_RECONFIG;
                S_WR_WDT_EN: state_d = S_RECONFIG;
                S_RECONFIG:  state_d = S_DONE;
                default:     state_d = state_q;
            endcase
        end
    end

    // Output / datapath next values.
    always_comb begin
        rsu_reset_d = rsu_reset_q;
        param_d     = param_q;
        data_d      = data_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        reconfig_d  = reconfig_q;
        trigger_d   = trigger_q;
        fault_d     = fault_q;
        sel_d       = sel_q;
        settle_d    = settle_q;
        if (tmo_c) begin
            fault_d = 2'd3;
        end else if (gate_c) begin
            case (state_q)
                S_RESET: begin
                    rsu_reset_d = 1'b0;
                    settle_d    = 1'b0;
                end
                S_SETTLE: settle_d = 1'b1;
                S_READ_TRIG: begin
                    param_d = 3'b111;
                    rd_d    = 1'b1;
                end
                S_FETCH: begin
                    trigger_d = rsu.rsu_data_out[4:0];
                    sel_d     = image_sel;
                    if (trig_err_c)     fault_d = 2'd1;
                    else if (sel_bad_c) fault_d = 2'd2;
                end
                S_WR_ADDR: begin
                    param_d = 3'b100;
                    data_d  = addr_c;
                    wr_d    = 1'b1;
                end
                S_WR_WDT: begin
                    if (WDT_ENABLE) begin
                        param_d = 3'b010;
                        data_d  = {12'h000, WDT_TIMEOUT};
                    end else begin
                        param_d = 3'b011;
                        data_d  = 24'h000000;
                    end
                    wr_d = 1'b1;
                end
                S_WR_WDT_EN: begin
                    param_d = 3'b011;
                    data_d  = 24'h000001;
                    wr_d    = 1'b1;
                end
                S_RECONFIG: reconfig_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign rsu.rsu_reset       = rsu_reset_q;
    assign rsu.rsu_param       = param_q;
    assign rsu.rsu_read_param  = rd_q;
    assign rsu.rsu_write_param = wr_q;
    assign rsu.rsu_data_in     = data_q;
    assign rsu.rsu_reconfig    = reconfig_q;
    // Bypass follows the mode pin combinationally so release is visible in the same cycle.
    assign bypass_spi          = (state_q == S_HOLD) && !mode_n;
    assign trigger             = trigger_q;
    assign fault               = fault_q;
    assign done                = (state_q == S_DONE) || (state_q == S_ERROR);

endmodule

// File: tb/tb_rsu_boot_ctrl.sv
module tb_rsu_boot_ctrl;

    logic       clock;
    logic       reset0, reset1;
    logic       mode_n;
    logic [2:0] image_sel;
    logic       bypass0, bypass1;
    logic [4:0] trigger0, trigger1;
    logic [1:0] fault0, fault1;
    logic       done0, done1;

    rsu_boot_ctrl_if rsu0 ();
    rsu_boot_ctrl_if rsu1 ();

    rsu_boot_ctrl dut0 (
        .clock      (clock),
        .reset      (reset0),
        .mode_n     (mode_n),
        .image_sel  (image_sel),
        .rsu        (rsu0),
        .bypass_spi (bypass0),
        .trigger    (trigger0),
        .fault      (fault0),
        .done       (done0)
    );

    rsu_boot_ctrl #(
        .WDT_ENABLE  (1'b1),
        .WDT_TIMEOUT (12'h0A5)
    ) dut1 (
        .clock      (clock),
        .reset      (reset1),
        .mode_n     (mode_n),
        .image_sel  (image_sel),
        .rsu        (rsu1),
        .bypass_spi (bypass1),
        .trigger    (trigger1),
        .fault      (fault1),
        .done       (done1)
    );

    always #5 clock = ~clock;

    // Bus recorders: write log, read count, back-to-back strobe and strobe-while-busy counters.
    int         wr_n0 = 0, rd_n0 = 0, dbl0 = 0, viol0 = 0;
    int         wr_n1 = 0, rd_n1 = 0, dbl1 = 0, viol1 = 0;
    logic [2:0] log_p0 [16];
    logic [23:0] log_d0 [16];
    logic [2:0] log_p1 [16];
    logic [23:0] log_d1 [16];
    logic       wrp0 = 1'b0, bsy0 = 1'b0, wrp1 = 1'b0, bsy1 = 1'b0;

    always @(posedge clock) begin
        if (rsu0.rsu_write_param) begin
            if (wr_n0 < 16) begin
                log_p0[wr_n0] <= rsu0.rsu_param;
                log_d0[wr_n0] <= rsu0.rsu_data_in;
            end
            wr_n0 <= wr_n0 + 1;
        end
        if (rsu0.rsu_read_param) rd_n0 <= rd_n0 + 1;
        if (rsu0.rsu_write_param && wrp0) dbl0 <= dbl0 + 1;
        if ((rsu0.rsu_write_param || rsu0.rsu_read_param) && bsy0) viol0 <= viol0 + 1;
        wrp0 <= rsu0.rsu_write_param;
        bsy0 <= rsu0.rsu_busy;

        if (rsu1.rsu_write_param) begin
            if (wr_n1 < 16) begin
                log_p1[wr_n1] <= rsu1.rsu_param;
                log_d1[wr_n1] <= rsu1.rsu_data_in;
            end
            wr_n1 <= wr_n1 + 1;
        end
        if (rsu1.rsu_read_param) rd_n1 <= rd_n1 + 1;
        if (rsu1.rsu_write_param && wrp1) dbl1 <= dbl1 + 1;
        if ((rsu1.rsu_write_param || rsu1.rsu_read_param) && bsy1) viol1 <= viol1 + 1;
        wrp1 <= rsu1.rsu_write_param;
        bsy1 <= rsu1.rsu_busy;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic run_to_done0(input int lim);
        for (int i = 0; i < lim && !done0; i++) tick(1);
    endtask

    task automatic pulse_reset0();
        reset0 = 1'b1;
        tick(1);
        reset0 = 1'b0;
    endtask

    initial begin
        int b, r, nb;
        clock     = 1'b0;
        reset0    = 1'b1;
        reset1    = 1'b1;
        mode_n    = 1'b1;
        image_sel = 3'd1;
        rsu0.rsu_busy = 1'b0;
        rsu0.rsu_data_out = 29'h0;
        rsu1.rsu_busy = 1'b0;
        rsu1.rsu_data_out = 29'h0;
        tick(2);

        // Reset state
        chk("rst_ctl", 64'({rsu0.rsu_reset, rsu0.rsu_read_param, rsu0.rsu_write_param,
                            rsu0.rsu_reconfig, bypass0, done0}), 64'(6'b100000));
        chk("rst_vals", 64'({rsu0.rsu_param, rsu0.rsu_data_in, trigger0, fault0}), 64'd0);

        // Normal boot of image 1, no watchdog
        rsu0.rsu_data_out = 29'h4;
        b = wr_n0;
        r = rd_n0;
        reset0 = 1'b0;
        run_to_done0(200);
        chk("t1_done", 64'(done0), 64'd1);
        chk("t1_nwr", 64'(wr_n0 - b), 64'd2);
        chk("t1_nrd", 64'(rd_n0 - r), 64'd1);
        chk("t1_w0", 64'({log_p0[b], log_d0[b]}), 64'({3'b100, 24'h200000}));
        chk("t1_w1", 64'({log_p0[b+1], log_d0[b+1]}), 64'({3'b011, 24'h000000}));
        chk("t1_state", 64'({rsu0.rsu_reconfig, rsu0.rsu_reset, fault0, trigger0, bypass0}),
            64'({1'b1, 1'b0, 2'd0, 5'b00100, 1'b0}));

        // Failed-boot trigger
        rsu0.rsu_data_out = 29'h2;
        b = wr_n0;
        pulse_reset0();
        run_to_done0(200);
        chk("t2_done", 64'(done0), 64'd1);
        chk("t2_fault", 64'({fault0, trigger0}), 64'({2'd1, 5'b00010}));
        chk("t2_nwr", 64'(wr_n0 - b), 64'd0);
        chk("t2_reconf", 64'(rsu0.rsu_reconfig), 64'd0);

        // Hold in bypass for 500 cycles, then release
        rsu0.rsu_data_out = 29'h0;
        image_sel = 3'd0;
        mode_n = 1'b0;
        b = wr_n0;
        pulse_reset0();
        for (int i = 0; i < 50 && !bypass0; i++) tick(1);
        chk("t3_bypass_on", 64'(bypass0), 64'd1);
        nb = 0;
        for (int i = 0; i < 500; i++) begin
            if (bypass0) nb++;
            tick(1);
        end
        chk("t3_bypass_cnt", 64'(nb), 64'd500);
        chk("t3_hold_nwr", 64'(wr_n0 - b), 64'd0);
        mode_n = 1'b1;
        #1;
        chk("t3_bypass_off", 64'(bypass0), 64'd0);
        run_to_done0(200);
        chk("t3_w0", 64'({log_p0[b], log_d0[b]}), 64'({3'b100, 24'h100000}));
        chk("t3_end", 64'({rsu0.rsu_reconfig, fault0, done0}), 64'({1'b1, 2'd0, 1'b1}));

        // Out-of-range image select
        image_sel = 3'd2;
        b = wr_n0;
        pulse_reset0();
        run_to_done0(200);
        chk("t5a_fault", 64'({done0, fault0}), 64'({1'b1, 2'd2}));
        chk("t5a_nwr", 64'({rsu0.rsu_reconfig, 8'(wr_n0 - b)}), 64'd0);

        // Busy stuck high after the trigger read
        image_sel = 3'd0;
        b = wr_n0;
        pulse_reset0();
        for (int i = 0; i < 50 && !rsu0.rsu_read_param; i++) tick(1);
        chk("t5b_rd", 64'(rsu0.rsu_read_param), 64'd1);
        rsu0.rsu_busy = 1'b1;
        tick(1020);
        chk("t5b_early", 64'({done0, fault0}), 64'd0);
        for (int i = 0; i < 20 && !done0; i++) tick(1);
        chk("t5b_fault", 64'({done0, fault0}), 64'({1'b1, 2'd3}));
        chk("t5b_nwr", 64'(wr_n0 - b), 64'd0);
        rsu0.rsu_busy = 1'b0;

        // Reset in WR_WDT, then a clean rerun
        image_sel = 3'd1;
        rsu0.rsu_data_out = 29'h4;
        pulse_reset0();
        for (int i = 0; i < 100 && !rsu0.rsu_write_param; i++) tick(1);
        chk("t6_first_wr", 64'({rsu0.rsu_write_param, rsu0.rsu_param}), 64'({1'b1, 3'b100}));
        reset0 = 1'b1;
        tick(1);
        chk("t6_rst_ctl", 64'({rsu0.rsu_reset, rsu0.rsu_read_param, rsu0.rsu_write_param,
                               rsu0.rsu_reconfig, bypass0, done0}), 64'(6'b100000));
        chk("t6_rst_vals", 64'({rsu0.rsu_param, rsu0.rsu_data_in, trigger0, fault0}), 64'd0);
        reset0 = 1'b0;
        b = wr_n0;
        run_to_done0(200);
        chk("t6_nwr", 64'(wr_n0 - b), 64'd2);
        chk("t6_w0", 64'({log_p0[b], log_d0[b]}), 64'({3'b100, 24'h200000}));
        chk("t6_w1", 64'({log_p0[b+1], log_d0[b+1]}), 64'({3'b011, 24'h000000}));
        chk("t6_end", 64'({rsu0.rsu_reconfig, fault0, done0}), 64'({1'b1, 2'd0, 1'b1}));
        chk("dut0_strobes", 64'({8'(dbl0), 8'(viol0)}), 64'd0);

        // Watchdog variant, with busy asserted after every write
        image_sel = 3'd1;
        mode_n = 1'b1;
        rsu1.rsu_data_out = 29'h4;
        b = wr_n1;
        reset1 = 1'b0;
        for (int i = 0; i < 300 && !done1; i++) begin
            if (rsu1.rsu_write_param) begin
                rsu1.rsu_busy = 1'b1;
                tick(3);
                rsu1.rsu_busy = 1'b0;
            end else begin
                tick(1);
            end
        end
        chk("t4_done", 64'(done1), 64'd1);
        chk("t4_nwr", 64'(wr_n1 - b), 64'd3);
        chk("t4_w0", 64'({log_p1[b], log_d1[b]}), 64'({3'b100, 24'h200000}));
        chk("t4_w1", 64'({log_p1[b+1], log_d1[b+1]}), 64'({3'b010, 24'h0000A5}));
        chk("t4_w2", 64'({log_p1[b+2], log_d1[b+2]}), 64'({3'b011, 24'h000001}));
        chk("t4_strobes", 64'({8'(dbl1), 8'(viol1)}), 64'd0);
        chk("t4_end", 64'({rsu1.rsu_reconfig, fault1}), 64'({1'b1, 2'd0}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
